uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 tb/tb_uart_tx_fifo.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// UART TX FIFO bus: byte write port, fill status, transmitter handshake
// and overflow control. The FIFO itself connects through the slave modport.
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      wr_data;
    logic            wr_en;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] count;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            tx_busy;
    logic            tx_done;
    logic            overflow;
    logic            ovf_clr;

    modport master (
        output wr_data, wr_en, tx_busy, tx_done, ovf_clr,
        input  full, empty, count, tx_data, tx_start, overflow
    );

    modport slave (
        input  wr_data, wr_en, tx_busy, tx_done, ovf_clr,
        output full, empty, count, tx_data, tx_start, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a start/busy/done handshake.
// Define UART_TX_FIFO_OVF_EN to enable the sticky write-while-full overflow flag.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic           clk,
    input logic           rst,
    uart_tx_fifo_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] CNT_ONE  = 1;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_nxt;
    logic              full_q;
    logic              empty_q;
    logic [7:0]        tx_data_q;
    logic              tx_start_q;
    logic              wr_acc;
    logic              pop;
    state_t            state;

    always_comb begin
        wr_acc    = bus.wr_en && !full_q;
        pop       = (state == IDLE) && !empty_q && !bus.tx_busy;
        count_nxt = count_q;
        case ({wr_acc, pop})
            2'b10:   count_nxt = count_q + CNT_ONE;
            2'b01:   count_nxt = count_q - CNT_ONE;
            default: count_nxt = count_q;
        endcase
    end

    // Storage carries no reset; stale bytes are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            state      <= IDLE;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count_q    <= count_nxt;
            empty_q    <= (count_nxt == '0);
            full_q     <= (count_nxt == FULL_CNT);
            tx_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data_q  <= mem[rd_ptr];
                        tx_start_q <= 1'b1;
                        state      <= START;
                    end
                end
                START:     state <= WAIT_ACK;
                WAIT_ACK:  if (bus.tx_busy) state <= WAIT_DONE;
                WAIT_DONE: if (bus.tx_done) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    assign bus.count    = count_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q;

    // Clear wins over a same-cycle dropped write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ovf_q <= 1'b0;
        else if (bus.ovf_clr)
            ovf_q <= 1'b0;
        else if (bus.wr_en && full_q)
            ovf_q <= 1'b1;
    end

    assign bus.overflow = ovf_q;
`else
    logic ovf_clr_unused;

    assign ovf_clr_unused = bus.ovf_clr;
    assign bus.overflow   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: the driver queues expected bytes, a
// negedge monitor checks every tx_start against the queue head.
module tb_uart_tx_fifo;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
`ifdef UART_TX_FIFO_OVF_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic       auto_tx  = 1'b0;
    logic       man_busy = 1'b0;
    logic       man_done = 1'b0;
    logic       m_busy   = 1'b0;
    logic       m_done   = 1'b0;
    logic [7:0] exp_q[$];
    int         n_cmp     = 0;
    int         n_bad     = 0;
    int         start_cnt = 0;

    assign bus.tx_busy = auto_tx ? m_busy : man_busy;
    assign bus.tx_done = auto_tx ? m_done : man_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every start pulse must match the oldest outstanding byte.
    always @(negedge clk) begin
        if (rst && bus.tx_start) begin
            start_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_start: got start with tx_data=%0h expected no start", bus.tx_data);
            end else begin
                check("tx_data", {24'h0, bus.tx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Automatic transmitter: busy for a few cycles, then a done pulse.
    initial begin
        forever begin
            tick();
            if (auto_tx && bus.tx_start) begin
                m_busy = 1'b1;
                tick();
                tick();
                tick();
                m_busy = 1'b0;
                m_done = 1'b1;
                tick();
                m_done = 1'b0;
            end
        end
    end

    task automatic write_byte(input logic [7:0] d, input logic kept);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        if (kept)
            exp_q.push_back(d);
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (!bus.tx_start && n < 60) begin
            tick();
            n++;
        end
        if (!bus.tx_start)
            check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Called in the START cycle: acknowledge and complete one frame.
    task automatic ack_frame();
        man_busy = 1'b1;
        tick();
        tick();
        man_busy = 1'b0;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time expired, expected completion");
        $fatal(1);
    end

    initial begin
        int s0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.ovf_clr = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_count", {27'h0, bus.count}, 32'd0);
        check("rst_empty", {31'h0, bus.empty}, 32'd1);
        check("rst_full", {31'h0, bus.full}, 32'd0);
        check("rst_tx_start", {31'h0, bus.tx_start}, 32'd0);
        check("rst_tx_data", {24'h0, bus.tx_data}, 32'h00);
        check("rst_overflow", {31'h0, bus.overflow}, 32'd0);
        rst = 1'b1;

        // Single byte: start two cycles after the write cycle
        write_byte(8'hA5, 1'b1);
        check("single_count", {27'h0, bus.count}, 32'd1);
        tick();
        check("single_start_n2", {31'h0, bus.tx_start}, 32'd1);
        check("single_empty_n2", {31'h0, bus.empty}, 32'd1);
        ack_frame();

        // Handshake: busy withheld keeps the FSM waiting with tx_data stable
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        check("hs_start", {31'h0, bus.tx_start}, 32'd1);
        s0 = start_cnt;
        repeat (10) tick();
        check("hs_no_restart", start_cnt, s0 + 1);
        check("hs_data_hold", {24'h0, bus.tx_data}, 32'h11);
        check("hs_count", {27'h0, bus.count}, 32'd1);
        man_busy = 1'b1;
        tick();
        tick();
        man_busy = 1'b0;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        wait_start("hs_second");
        ack_frame();

        // Full and overflow with the transmitter held busy
        man_busy = 1'b1;
        for (int i = 0; i < 17; i++)
            write_byte(8'h30 + 8'(i), i < 16);
        check("full_flag", {31'h0, bus.full}, 32'd1);
        check("full_count", {27'h0, bus.count}, 32'd16);
        check("full_overflow", {31'h0, bus.overflow}, {31'h0, EXP_OVF});
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_cleared", {31'h0, bus.overflow}, 32'd0);
        bus.ovf_clr = 1'b1;
        write_byte(8'hEE, 1'b0);
        bus.ovf_clr = 1'b0;
        check("ovf_clr_priority", {31'h0, bus.overflow}, 32'd0);
        check("full_count_after_drop", {27'h0, bus.count}, 32'd16);
        man_busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wait_start("drain_full");
            ack_frame();
        end
        check("drain_empty", {31'h0, bus.empty}, 32'd1);

        // Simultaneous write and pop at count 5
        man_busy = 1'b1;
        for (int i = 0; i < 5; i++)
            write_byte(8'h50 + 8'(i), 1'b1);
        check("sim_count5", {27'h0, bus.count}, 32'd5);
        man_busy = 1'b0;
        write_byte(8'h55, 1'b1);
        check("sim_count_hold", {27'h0, bus.count}, 32'd5);
        check("sim_start", {31'h0, bus.tx_start}, 32'd1);
        ack_frame();
        for (int i = 0; i < 5; i++) begin
            wait_start("sim_drain");
            ack_frame();
        end

        // Ordering across pointer wrap with a free-running transmitter
        auto_tx = 1'b1;
        s0 = start_cnt;
        for (int i = 0; i < 20; i++) begin
            write_byte(8'(i), 1'b1);
            tick();
        end
        for (int i = 0; i < 400 && exp_q.size() != 0; i++)
            tick();
        repeat (8) tick();
        check("wrap_all_sent", exp_q.size(), 32'd0);
        check("wrap_frames", start_cnt - s0, 32'd20);
        check("wrap_empty", {31'h0, bus.empty}, 32'd1);
        auto_tx = 1'b0;

        // Reset mid-frame with three bytes queued behind a frame in WAIT_DONE
        write_byte(8'h61, 1'b1);
        wait_start("mid_first");
        man_busy = 1'b1;
        write_byte(8'h62, 1'b0);
        write_byte(8'h63, 1'b0);
        write_byte(8'h64, 1'b0);
        check("mid_count3", {27'h0, bus.count}, 32'd3);
        rst = 1'b0;
        tick();
        tick();
        check("mid_rst_count", {27'h0, bus.count}, 32'd0);
        check("mid_rst_empty", {31'h0, bus.empty}, 32'd1);
        check("mid_rst_start", {31'h0, bus.tx_start}, 32'd0);
        s0 = start_cnt;
        rst = 1'b1;
        man_busy = 1'b0;
        repeat (20) tick();
        check("mid_no_frames", start_cnt, s0);
        check("mid_empty_after", {31'h0, bus.empty}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
